// File: rtl/hslp_pipe_mul_pkg.sv
// Shared definitions for the HSLP pipelined approximate multiplier.
// Mode field layout, truncation level type and mask helper.
package hslp_pipe_mul_pkg;

  localparam int MODE_HH = 6;
  localparam int MODE_HL = 4;
  localparam int MODE_LH = 2;
  localparam int MODE_LL = 0;

  typedef logic [1:0] lvl_t;

  function automatic logic [31:0] trunc_mask(
    input lvl_t lvl,
    input int   step
  );
    logic [31:0] m;
    m = '1;
    return m << (int'(lvl) * step);
  endfunction

endpackage

// File: rtl/hslp_quad_trunc.sv
// One H x H quadrant product with its low
// lvl*TRUNC_STEP bits forced to zero.
module hslp_quad_trunc
  import hslp_pipe_mul_pkg::*;
#(
  parameter int H          = 4,
  parameter int TRUNC_STEP = 1
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  lvl_t           lvl,
  output logic [2*H-1:0] p
);

  logic [2*H-1:0] full;
  logic [2*H-1:0] m;

  assign full = (2*H)'(x) * (2*H)'(y);
  assign m    = (2*H)'(trunc_mask(lvl, TRUNC_STEP));
  assign p    = full & m;

endmodule

// File: rtl/hslp_pipe_mul.sv
// Pipelined HSLP approximate multiplier: quadrant stage,
// sum stage, valid/ready backpressure and a txn counter.
module hslp_pipe_mul
  import hslp_pipe_mul_pkg::*;
#(
  parameter int W          = 8,
  parameter int TRUNC_STEP = 1,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [7:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     prod,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] txn_count
);

  localparam int H = W / 2;

  logic [2*H-1:0] hh, hl, lh, ll;
  logic [2*H-1:0] qhh, qhl, qlh, qll;
  logic           va, vb;
  logic           adv_a, adv_b;
  logic [2*W-1:0] sum;

  hslp_quad_trunc #(.H(H), .TRUNC_STEP(TRUNC_STEP)) u_hh (
    .x(a[W-1:H]), .y(b[W-1:H]),
    .lvl(lvl_t'(mode[MODE_HH +: 2])), .p(hh)
  );

  hslp_quad_trunc #(.H(H), .TRUNC_STEP(TRUNC_STEP)) u_hl (
    .x(a[W-1:H]), .y(b[H-1:0]),
    .lvl(lvl_t'(mode[MODE_HL +: 2])), .p(hl)
  );

  hslp_quad_trunc #(.H(H), .TRUNC_STEP(TRUNC_STEP)) u_lh (
    .x(a[H-1:0]), .y(b[W-1:H]),
    .lvl(lvl_t'(mode[MODE_LH +: 2])), .p(lh)
  );

  hslp_quad_trunc #(.H(H), .TRUNC_STEP(TRUNC_STEP)) u_ll (
    .x(a[H-1:0]), .y(b[H-1:0]),
    .lvl(lvl_t'(mode[MODE_LL +: 2])), .p(ll)
  );

  assign adv_b    = !vb || out_ready;
  assign adv_a    = !va || adv_b;
  assign in_ready = adv_a;

  // Truncation only lowers the exact product, so 2W bits never overflow.
  always_comb begin
    sum = ((2*W)'(qhh) << W)
        + (((2*W)'(qhl) + (2*W)'(qlh)) << H)
        + (2*W)'(qll);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va  <= 1'b0;
      qhh <= '0;
      qhl <= '0;
      qlh <= '0;
      qll <= '0;
    end else if (adv_a) begin
      va <= in_valid;
      if (in_valid) begin
        qhh <= hh;
        qhl <= hl;
        qlh <= lh;
        qll <= ll;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb   <= 1'b0;
      prod <= '0;
    end else if (adv_b) begin
      vb <= va;
      if (va) begin
        prod <= sum;
      end
    end
  end

  assign out_valid = vb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (cnt_clr) begin
      txn_count <= '0;
    end else if (vb && out_ready) begin
      txn_count <= txn_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hslp_pipe_mul.sv
// Directed and streaming checks for hslp_pipe_mul
// (W=8, TRUNC_STEP=1, COUNT_W=4).
module tb_hslp_pipe_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [7:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] prod;
  logic        cnt_clr = 1'b0;
  logic [3:0]  txn_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_in = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  bit          done = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  hslp_pipe_mul #(.W(8), .TRUNC_STEP(1), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod),
    .cnt_clr(cnt_clr), .txn_count(txn_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q(input logic [3:0] x,
                                   input logic [3:0] y,
                                   input logic [1:0] l);
    logic [7:0] p, mk;
    p  = {4'h0, x} * {4'h0, y};
    mk = 8'hFF;
    mk = mk << l;
    return p & mk;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic [7:0] m);
    logic [7:0]  hh, hl, lh, ll;
    logic [15:0] mid;
    hh  = q(x[7:4], y[7:4], m[7:6]);
    hl  = q(x[7:4], y[3:0], m[5:4]);
    lh  = q(x[3:0], y[7:4], m[3:2]);
    ll  = q(x[3:0], y[3:0], m[1:0]);
    mid = {8'h00, hl} + {8'h00, lh};
    mid = mid << 4;
    return {hh, 8'h00} + mid + {8'h00, ll};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 0);
        end else begin
          check("stream_prod", 32'(prod), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, mode));
        n_in++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x,
                      input logic [7:0] y,
                      input logic [7:0] m);
    a = x;
    b = y;
    mode = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_txn", 32'(txn_count), 0);
    check("rst_prod", 32'(prod), 0);
    #11;
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // exact product and latency
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 8'h00);
    check("lat_cycle1", 32'(out_valid), 0);
    step();
    check("lat_cycle2", 32'(out_valid), 1);
    check("exact_prod", 32'(prod), 32'h0000FE01);
    step();
    check("txn_first", 32'(txn_count), 1);
    check("empty_valid", 32'(out_valid), 0);
    check("empty_hold", 32'(prod), 32'h0000FE01);

    // back-to-back modes
    send(8'hFF, 8'hFF, 8'h03);
    send(8'hFF, 8'hFF, 8'h80);
    check("b2b_first", 32'(prod), 32'h0000FE00);
    step();
    check("b2b_second", 32'(prod), 32'h0000FD01);
    drain();
    check("txn_three", 32'(txn_count), 3);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h12; b = 8'h34; mode = 8'h00;
    step();
    a = 8'hA5; b = 8'h5A; mode = 8'h55;
    check("bp_ready_one", 32'(in_ready), 1);
    step();
    a = 8'h7F; b = 8'h81; mode = 8'hFF;
    check("bp_full", 32'(in_ready), 0);
    step();
    check("bp_still_full", 32'(in_ready), 0);
    check("bp_hold_prod", 32'(prod), 32'(model(8'h12, 8'h34, 8'h00)));
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    drain();
    check("bp_in_out", 32'(n_out), 32'(n_in));

    // random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          send(8'($urandom), 8'($urandom), 8'($urandom));
          if ($urandom_range(0, 3) == 0) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain();
    check("rand_in_out", 32'(n_out), 32'(n_in));
    check("rand_txn", 32'(txn_count), 32'(n_out % 16));

    // counter clear and wrap
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_idle", 32'(txn_count), 0);
    for (int i = 0; i < 17; i++) send(8'(i * 13), 8'(i * 7 + 3), 8'(i));
    drain();
    check("wrap", 32'(txn_count), 1);
    send(8'h9C, 8'h3E, 8'h21);
    step();
    check("clr_hs_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_priority", 32'(txn_count), 0);
    check("clr_hs_done", 32'(exp_q.size()), 0);

    // reset with both stages full
    out_ready = 1'b0;
    send(8'h11, 8'h22, 8'h00);
    send(8'h33, 8'h44, 8'h00);
    check("full_valid", 32'(out_valid), 1);
    check("full_ready", 32'(in_ready), 0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    check("mid_rst_txn", 32'(txn_count), 0);
    check("mid_rst_prod", 32'(prod), 0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_valid", 32'(out_valid), 0);
      step();
    end
    check("post_rst_txn", 32'(txn_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hslp_pipe_mul.md
Name: hslp_pipe_mul

Overview:
- Parametrised, pipelined successor to the fixed 8x8 HSLP approximate multiplier.
- Splits W-bit operands into high/low halves and forms four H x H quadrant products (hh, hl, lh, ll). Each quadrant has a runtime-selectable truncation level. The quadrants are summed into a 2W-bit product.
- Streams operands through a 2-stage valid/ready pipeline with full backpressure.
- Counts completed transactions for error-characterisation runs on FPGA.

Parameters:
- W, 8, operand width; even, 8..32; H = W/2.
- TRUNC_STEP, 1, bits zeroed per truncation level; 1..H/2.
- COUNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/mode beat valid
- in_ready  out  1  block can accept a beat
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- mode  in  8  truncation levels: [7:6] hh, [5:4] hl, [3:2] lh, [1:0] ll
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- prod  out  2W  approximate product, unsigned
- cnt_clr  in  1  synchronous clear of txn_count
- txn_count  out  COUNT_W  number of output handshakes since reset/clear

Behaviour:
- Reset: one clock; asynchronous, active-low. All valid flags, stage registers, prod and txn_count reset to 0; in_ready = 1 after reset.
- Quadrant products: ah = a[W-1:H], al = a[H-1:0], same split for b.
  - hh = ah*bh, hl = ah*bl, lh = al*bh, ll = al*bl; each is exact, 2H bits.
  - Level L (0..3) of a quadrant forces its low L*TRUNC_STEP bits to 0. L = 0 gives the exact quadrant.
- Sum: prod = (hh << W) + ((hl + lh) << H) + ll, computed at 2W+1 bits and truncated to 2W (no overflow is possible). All levels 0 gives the exact a*b.
- mode is sampled with a/b on the input handshake. A mode change takes effect per beat; beats already in flight keep their captured mode.
- Pipeline:
  - Stage A registers the four truncated quadrant products on in_valid & in_ready.
  - Stage B registers the sum and drives prod/out_valid.
  - Latency is 2 cycles from input handshake to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Handshake:
  - Stage B advances when !vB | out_ready.
  - Stage A advances when !vA | advB.
  - in_ready = !vA | advB, and is combinationally dependent on out_ready.
  - prod and out_valid hold stable while out_valid & !out_ready.
  - A beat is never dropped or duplicated.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. When out_ready rises, in_ready rises in the same cycle.
- Empty: out_valid = 0 and prod holds its last value (0 after reset).
- Counter: txn_count increments on out_valid & out_ready and wraps from 2^COUNT_W-1 to 0.
  - cnt_clr sets it to 0 on the next edge.
  - cnt_clr has priority over a simultaneous increment (result 0).
- Reset mid-operation discards all in-flight beats immediately; no output handshake occurs for them.

Decomposition:
- Shared package:
  - mode field offsets (MODE_HH = 6, MODE_HL = 4, MODE_LH = 2, MODE_LL = 0)
  - 2-bit level type
  - function computing the truncation mask from level and TRUNC_STEP
- One sub-module, hslp_quad_trunc: a combinational H x H multiply with level-controlled truncation, instantiated four times.
- Pipeline control and the adder stay in the top module.

Test Plan:
- W=8, mode=0x00, a=0xFF, b=0xFF, out_ready=1 -> prod=0xFE01, out_valid 2 cycles after the handshake, txn_count=1.
- W=8, a=b=0xFF: mode=0x03 (ll level 3) -> prod=0xFE00; mode=0x80 (hh level 2) -> prod=0xFD01; issue back-to-back, both returned in order.
- Streaming of 100 random beats with random modes and random out_ready (50%) -> every product matches the reference model in order, no loss or duplication, prod stable while stalled.
- Hold out_ready=0 while driving 3 beats -> in_ready=0 after 2 accepted; raise out_ready -> in_ready=1 in the same cycle and the third beat is accepted.
- COUNT_W=4, run 17 handshakes -> txn_count=1 (wrap). Assert cnt_clr on the same cycle as a handshake -> txn_count=0.
- Assert rst_n=0 with both stages full -> out_valid=0, in_ready=1 and txn_count=0 immediately; no stale product after reset release.
